alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the ALU rotate-right unit.
- Captures the 32-bit rotate result with its shift amount and opcode tag, and derives Z/N/C flags.
- Presents the result to writeback over a valid/ready handshake, with a 2-entry skid buffer so the rotator path never stalls on a registered ready.
- Also counts completed transfers for debug/perf.

Parameters:
- DATA_W, 32, result width; must match rotator width.
- SHAMT_W, 5, shift-amount width, log2(DATA_W).
- TAG_W, 3, opcode/destination tag width, passed through untouched.
- CNT_W, 16, width of the completed-transfer counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  stage can accept; registered, not combinationally dependent on out_ready.
- in_data  in  DATA_W  rotate result.
- in_shamt  in  SHAMT_W  rotate amount used to produce in_data.
- in_tag  in  TAG_W  opcode/destination tag.
- out_valid  out  1  result available downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  registered result.
- out_tag  out  TAG_W  registered tag.
- out_z  out  1  zero flag.
- out_n  out  1  negative flag.
- out_c  out  1  carry flag.
- xfer_cnt  out  CNT_W  count of output handshakes.

Behaviour:
- Handshake definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Flag computation, at capture, from in_data/in_shamt; stored with the entry:
  - Z = (in_data == 0).
  - N = in_data[DATA_W-1].
  - C = (in_shamt != 0) ? in_data[DATA_W-1] : 0. This is the last bit rotated out of bit 0.
- FSM states: EMPTY, ONE, FULL. Entries are main (drives the outputs) and skid.
- EMPTY:
  - out_valid = 0, in_ready = 1.
  - in_fire -> load main, go to ONE.
- ONE:
  - out_valid = 1, in_ready = 1.
  - in_fire & out_fire -> reload main, stay in ONE.
  - in_fire only -> load skid, go to FULL.
  - out_fire only -> go to EMPTY.
  - Neither -> hold.
- FULL:
  - out_valid = 1, in_ready = 0.
  - out_fire -> main <= skid, go to ONE.
  - in_valid is ignored.
- Ordering: strict FIFO; no entry is dropped or duplicated.
- Latency and throughput:
  - 1 cycle from in_fire to out_valid.
  - Sustained 1 transfer/cycle while out_ready = 1.
- Stability: while out_valid & !out_ready, out_data/out_tag/flags hold stable.
- Counter: xfer_cnt increments by 1 on each out_fire and wraps from 2^CNT_W-1 to 0.
- Reset (rst_n = 0 at a clk edge):
  - State = EMPTY, in_ready = 1, out_valid = 0.
  - out_data = 0, out_tag = 0, flags = 0, xfer_cnt = 0.
  - Reset mid-operation discards both entries; no partial handshake completes in the reset cycle.
- Data registers are loaded only on in_fire; no X propagation to the outputs after reset.

Decomposition:
- Shared package alu_pkg:
  - DATA_W/SHAMT_W constants.
  - State encoding: EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2.
  - Flag-bundle typedef {z, n, c}.
- One sub-module: alu_flag_gen, combinational Z/N/C from data and shamt. It is reusable by the other ALU function units.
- Entry storage and the FSM stay in alu_result_stage.

Test Plan:
1. Reset, then in_data = 0x80000001, shamt = 1, tag = 3, out_ready = 1 -> next cycle out_valid = 1, out_data = 0x80000001, Z = 0, N = 1, C = 1, out_tag = 3; xfer_cnt = 1 after the handshake.
2. in_data = 0x00000000, shamt = 0 -> Z = 1, N = 0, C = 0. Then in_data = 0xF0000000, shamt = 0 -> C = 0, N = 1.
3. Backpressure: out_ready = 0, send A = 0x11, B = 0x22 -> in_ready drops after B, state FULL, out_data holds 0x11. Then out_ready = 1 -> 0x11, then 0x22, in order; in_ready returns to 1 one cycle after the first out_fire.
4. Streaming 100 random results with out_ready = 1 -> one output per cycle, order preserved, xfer_cnt = 100. Repeat with random out_ready -> no loss or duplication.
5. Assert rst_n = 0 while FULL -> next cycle out_valid = 0, in_ready = 1, xfer_cnt = 0; the first post-reset input appears unchanged.
6. Preload xfer_cnt to 0xFFFF via 65535 transfers, then one more out_fire -> xfer_cnt = 0x0000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU function-unit result path.
package alu_pkg;

  localparam int ALU_DATA_W  = 32;
  localparam int ALU_SHAMT_W = 5;
  localparam int ALU_TAG_W   = 3;
  localparam int ALU_CNT_W   = 16;

  // Occupancy of the main/skid pair.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Condition flags carried alongside each result.
  typedef struct packed {
    logic z;
    logic n;
    logic c;
  } flags_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational Z/N/C flag derivation for a rotate-right result.
// C is the last bit rotated out of bit 0, which lands in the MSB;
// a zero rotate shifts nothing out, so C stays clear.
module alu_flag_gen #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               flag_z,
  output logic               flag_n,
  output logic               flag_c
);

  // Flags are pure functions of the result and the rotate amount.
  always_comb begin
    flag_z = (data == '0);
    flag_n = data[DATA_W-1];
    flag_c = (shamt != '0) ? data[DATA_W-1] : 1'b0;
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage behind the rotate-right unit. A main entry
// drives the outputs; a skid entry absorbs one extra result so that
// in_ready depends only on local state, never on out_ready.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_W  = ALU_DATA_W,
  parameter int SHAMT_W = ALU_SHAMT_W,
  parameter int TAG_W   = ALU_TAG_W,
  parameter int CNT_W   = ALU_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_z,
  output logic               out_n,
  output logic               out_c,
  output logic [CNT_W-1:0]   xfer_cnt
);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  main_data_q, main_data_d;
  logic [TAG_W-1:0]   main_tag_q, main_tag_d;
  flags_t             main_flags_q, main_flags_d;
  logic [DATA_W-1:0]  skid_data_q, skid_data_d;
  logic [TAG_W-1:0]   skid_tag_q, skid_tag_d;
  flags_t             skid_flags_q, skid_flags_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  flags_t             cap_flags;
  logic               in_fire;
  logic               out_fire;

  alu_flag_gen #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_flag_gen (
    .data   (in_data),
    .shamt  (in_shamt),
    .flag_z (cap_flags.z),
    .flag_n (cap_flags.n),
    .flag_c (cap_flags.c)
  );

  // Handshake status decoded from the state register only.
  always_comb begin
    in_ready  = (state_q != FULL);
    out_valid = (state_q != EMPTY);
    in_fire   = in_valid & in_ready;
    out_fire  = out_valid & out_ready;
  end

  // Next-state, entry movement and transfer counting.
  always_comb begin
    state_d      = state_q;
    main_data_d  = main_data_q;
    main_tag_d   = main_tag_q;
    main_flags_d = main_flags_q;
    skid_data_d  = skid_data_q;
    skid_tag_d   = skid_tag_q;
    skid_flags_d = skid_flags_q;
    cnt_d        = cnt_q + {{(CNT_W-1){1'b0}}, out_fire};

    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_data_d  = in_data;
          main_tag_d   = in_tag;
          main_flags_d = cap_flags;
          state_d      = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_data_d  = in_data;
          main_tag_d   = in_tag;
          main_flags_d = cap_flags;
        end else if (in_fire) begin
          skid_data_d  = in_data;
          skid_tag_d   = in_tag;
          skid_flags_d = cap_flags;
          state_d      = FULL;
        end else if (out_fire) begin
          state_d      = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_data_d  = skid_data_q;
          main_tag_d   = skid_tag_q;
          main_flags_d = skid_flags_q;
          state_d      = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State, entries and counter; reset clears everything so outputs are never X.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      main_data_q  <= '0;
      main_tag_q   <= '0;
      main_flags_q <= '0;
      skid_data_q  <= '0;
      skid_tag_q   <= '0;
      skid_flags_q <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      main_data_q  <= main_data_d;
      main_tag_q   <= main_tag_d;
      main_flags_q <= main_flags_d;
      skid_data_q  <= skid_data_d;
      skid_tag_q   <= skid_tag_d;
      skid_flags_q <= skid_flags_d;
      cnt_q        <= cnt_d;
    end
  end

  // Outputs come straight from the main entry.
  always_comb begin
    out_data = main_data_q;
    out_tag  = main_tag_q;
    out_z    = main_flags_q.z;
    out_n    = main_flags_q.n;
    out_c    = main_flags_q.c;
    xfer_cnt = cnt_q;
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_shamt = '0;
  logic [2:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_tag;
  logic        out_z, out_n, out_c;
  logic [15:0] xfer_cnt;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  tag;
    logic        z;
    logic        n;
    logic        c;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_cnt = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  alu_result_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_z     (out_z),
    .out_n     (out_n),
    .out_c     (out_c),
    .xfer_cnt  (xfer_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Rotate-right flag semantics: C is the bit rotated out of bit 0 last.
  function automatic exp_t model(input logic [31:0] d, input logic [4:0] sh, input logic [2:0] tg);
    exp_t e;
    e.data = d;
    e.tag  = tg;
    e.z    = (d == 32'd0);
    e.n    = d[31];
    e.c    = (sh == 5'd0) ? 1'b0 : d[31];
    return e;
  endfunction

  // One clock cycle: drive at negedge, check against scoreboard, account for fires.
  task automatic step(input logic v, input logic [31:0] d, input logic [4:0] sh,
                      input logic [2:0] tg, input logic ordy);
    exp_t e;
    logic ifire, ofire;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_shamt  = sh;
    in_tag    = tg;
    out_ready = ordy;
    #1;
    chk("out_valid", out_valid, sb.size() != 0);
    chk("in_ready", in_ready, sb.size() < 2);
    chk("xfer_cnt", xfer_cnt, exp_cnt);
    if (out_valid && sb.size() > 0) begin
      e = sb[0];
      chk("out_data", out_data, e.data);
      chk("tag_zncf", {out_tag, out_z, out_n, out_c}, {e.tag, e.z, e.n, e.c});
    end
    ifire = v & in_ready;
    ofire = out_valid & ordy;
    if (ofire) begin
      exp_cnt++;
      if (sb.size() > 0) void'(sb.pop_front());
    end
    if (ifire) sb.push_back(model(d, sh, tg));
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 5'h0, 3'h0, ordy);
  endtask

  // Reset with in_valid/out_ready held high to show nothing completes.
  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    exp_cnt = '0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_tag_flags", {out_tag, out_z, out_n, out_c}, 6'h0);
    chk("rst_xfer_cnt", xfer_cnt, 16'h0);
  endtask

  initial begin
    do_reset();

    // Test 1: basic capture and flags
    step(1'b1, 32'h8000_0001, 5'd1, 3'd3, 1'b1);
    @(posedge clk); #1;
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_data", out_data, 32'h8000_0001);
    chk("t1_tag_zncf", {out_tag, out_z, out_n, out_c}, {3'd3, 1'b0, 1'b1, 1'b1});
    idle(1'b1);
    @(posedge clk); #1;
    chk("t1_cnt", xfer_cnt, 16'd1);

    // Test 2: zero result and zero-shift carry
    step(1'b1, 32'h0000_0000, 5'd0, 3'd5, 1'b1);
    @(posedge clk); #1;
    chk("t2_zero_znc", {out_z, out_n, out_c}, 3'b100);
    step(1'b1, 32'hF000_0000, 5'd0, 3'd6, 1'b1);
    @(posedge clk); #1;
    chk("t2_neg_znc", {out_z, out_n, out_c}, 3'b010);
    idle(1'b1);
    idle(1'b1);

    // Test 3: backpressure into the skid entry
    step(1'b1, 32'h11, 5'd4, 3'd1, 1'b0);
    step(1'b1, 32'h22, 5'd8, 3'd2, 1'b0);
    step(1'b1, 32'h33, 5'd8, 3'd4, 1'b0);
    chk("t3_full_ready", in_ready, 1'b0);
    chk("t3_hold_data", out_data, 32'h11);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("t3_ready_back", in_ready, 1'b1);
    chk("t3_second", out_data, 32'h22);
    idle(1'b1);

    // Test 4a: streaming at full rate
    begin
      logic [15:0] c0;
      c0 = exp_cnt;
      for (int i = 0; i < 100; i++)
        step(1'b1, $urandom, 5'($urandom_range(0, 31)), 3'($urandom), 1'b1);
      idle(1'b1);
      idle(1'b1);
      chk("t4_cnt100", xfer_cnt - c0, 16'd100);
    end

    // Test 4b: random valid and ready
    for (int i = 0; i < 300; i++)
      step(1'($urandom), $urandom, 5'($urandom_range(0, 31)), 3'($urandom), 1'($urandom));
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("t4_drained", sb.size(), 0);

    // Test 5: reset while FULL
    step(1'b1, 32'hAAAA_0001, 5'd3, 3'd1, 1'b0);
    step(1'b1, 32'hBBBB_0002, 5'd0, 3'd2, 1'b0);
    idle(1'b0);
    do_reset();
    step(1'b1, 32'hDEAD_BEEF, 5'd7, 3'd2, 1'b0);
    @(posedge clk); #1;
    chk("t5_first_data", out_data, 32'hDEAD_BEEF);
    chk("t5_first_tag_zncf", {out_tag, out_z, out_n, out_c}, {3'd2, 1'b0, 1'b1, 1'b1});
    idle(1'b1);
    idle(1'b1);

    // Test 6: counter wrap
    for (int i = 0; i < 70000 && exp_cnt != 16'hFFFF; i++)
      step(1'b1, $urandom, 5'($urandom_range(0, 31)), 3'($urandom), 1'b1);
    chk("t6_reach_ffff", exp_cnt, 16'hFFFF);
    idle(1'b1);
    @(posedge clk); #1;
    chk("t6_wrap", xfer_cnt, 16'h0000);
    idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
